// File: rtl/jtframe_ram_fifo_if.sv
// FIFO request/status bundle: the producer/consumer side uses master, the FIFO uses slave.
// The dw/aw values must match the parameters of the FIFO this bundle is connected to.
interface jtframe_ram_fifo_if #(
  parameter int dw = 8,
  parameter int aw = 4
);
  logic          clr;
  logic          wr;
  logic [dw-1:0] din;
  logic          rd;
  logic [dw-1:0] dout;
  logic          empty;
  logic          full;
  logic          afull;
  logic [aw:0]   level;
  logic          ovf;
  logic          unf;

  modport master (
    output clr, wr, din, rd,
    input  dout, empty, full, afull, level, ovf, unf
  );

  modport slave (
    input  clr, wr, din, rd,
    output dout, empty, full, afull, level, ovf, unf
  );
endinterface

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM with a registered read on each port.
// Both write ports are captured on clk0, so the two ports are meant to share one clock.
module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 4
) (
  input  logic          clk0,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic          clk1,
  input  logic [dw-1:0] data1,
  input  logic [aw-1:0] addr1,
  input  logic          we1,
  output logic [dw-1:0] q1
);
  logic [dw-1:0] mem [2**aw];

  // NOTE: the array and read registers have no reset so the storage maps onto block RAM.
  always_ff @(posedge clk0) begin
    if (we1) mem[addr1] <= data1;
    if (we0) mem[addr0] <= data0;
    q0 <= mem[addr0];
  end

  always_ff @(posedge clk1) begin
    q1 <= mem[addr1];
  end
endmodule

// File: rtl/jtframe_ram_fifo.sv
// Show-ahead FIFO on top of jtframe_dual_ram: port 0 writes, port 1 reads.
// The registered empty flag hides the RAM read latency, so dout is valid whenever empty is low.
module jtframe_ram_fifo #(
  parameter int dw    = 8,
  parameter int aw    = 4,
  parameter int AFULL = 2**aw - 2
) (
  input logic                clk,
  input logic                rst_n,
  jtframe_ram_fifo_if.slave  bus
);
  localparam logic [aw:0] DEPTH     = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] ONE       = {{aw{1'b0}}, 1'b1};
  localparam logic [aw:0] AFULL_LVL = AFULL[aw:0];

  logic [aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [aw:0]   level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wa, ra, ram_we;
  logic [dw-1:0] ram_q1;
  logic [dw-1:0] ram_q0_unused;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wa       = bus.wr & ~full_q;
    ra       = bus.rd & ~empty_q;
    ram_we   = wa & ~bus.clr;
    wr_ptr_d = wa ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = ra ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({wa, ra})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
    ovf_d    = ovf_q | (bus.wr & full_q);
    unf_d    = unf_q | (bus.rd & empty_q);
    // The new head is readable only if it was already in RAM before this edge;
    // a word written at this very edge gets one cycle of empty while port 1 catches up.
    empty_d  = (level_q == '0) || (ra && (level_q == ONE));
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      empty_d  = 1'b1;
    end
    full_d   = (level_d == DEPTH);
    afull_d  = (level_d >= AFULL_LVL);
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Port 1 is addressed with the next read pointer so the popped-to word lands on q1 with no bubble.
  jtframe_dual_ram #(
    .dw (dw),
    .aw (aw)
  ) u_ram (
    .clk0  (clk),
    .data0 (bus.din),
    .addr0 (wr_ptr_q),
    .we0   (ram_we),
    .q0    (ram_q0_unused),
    .clk1  (clk),
    .data1 ('0),
    .addr1 (rd_ptr_d),
    .we1   (1'b0),
    .q1    (ram_q1)
  );

  assign bus.dout  = ram_q1;
  assign bus.empty = empty_q;
  assign bus.full  = full_q;
  assign bus.afull = afull_q;
  assign bus.level = level_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: tb/tb_jtframe_ram_fifo.sv
// Self-checking bench for jtframe_ram_fifo (aw=2, dw=8, AFULL=3) against a queue-based model.
module tb_jtframe_ram_fifo;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  typedef struct {
    logic [DW-1:0] data;
    int            t;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  entry_t q[$];
  bit     m_ovf, m_unf;
  int     n_edge = 0;

  jtframe_ram_fifo_if #(.dw(DW), .aw(AW)) bus ();

  jtframe_ram_fifo #(
    .dw    (DW),
    .aw    (AW),
    .AFULL (AFULL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end within the time limit");
    $fatal(1, "watchdog");
  end

  // Head is readable once it has sat in the queue across at least one full cycle.
  function automatic bit exp_empty();
    return (q.size() == 0) || (q[0].t == n_edge);
  endfunction

  function automatic logic [7:0] exp_status();
    logic [2:0] lvl;
    lvl = 3'(q.size());
    return {exp_empty(), q.size() == DEPTH, q.size() >= AFULL, m_ovf, m_unf, lvl};
  endfunction

  function automatic logic [7:0] dut_status();
    return {bus.empty, bus.full, bus.afull, bus.ovf, bus.unf, bus.level};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  task automatic cycle(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    bit full_e, empty_e;
    bus.wr  = w;
    bus.rd  = r;
    bus.clr = c;
    bus.din = d;
    @(posedge clk);
    full_e  = (q.size() == DEPTH);
    empty_e = exp_empty();
    if (c) begin
      model_reset();
    end else begin
      if (w && full_e)  m_ovf = 1'b1;
      if (r && empty_e) m_unf = 1'b1;
      if (r && !empty_e) void'(q.pop_front());
      if (w && !full_e)  q.push_back(entry_t'{data: d, t: n_edge + 1});
    end
    n_edge++;
    #1;
  endtask

  task automatic test_reset();
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0; bus.din = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (dut_status() !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_status: got %b expected %b", dut_status(), 8'b1000_0000);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    cycle(1, 0, 0, 8'hA1);
    n_checks++;
    if (bus.level !== 3'd1 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_after_write: level=%0d empty=%b expected level=1 empty=1", bus.level, bus.empty);
    end
    cycle(0, 0, 0, 8'h00);
    n_checks++;
    if (bus.empty !== 1'b0 || bus.dout !== 8'hA1) begin
      n_fail++;
      $display("FAIL single_valid: empty=%b dout=%h expected empty=0 dout=a1", bus.empty, bus.dout);
    end
    cycle(0, 1, 0, 8'h00);
    n_checks++;
    if (dut_status() !== exp_status() || bus.level !== 3'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pop: got %b expected %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_fill_ovf();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 8'(8'h10 + i));
      n_checks++;
      if (dut_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL fill_status_%0d: got %b expected %b", i, dut_status(), exp_status());
      end
    end
    n_checks++;
    if (bus.full !== 1'b1 || bus.afull !== 1'b1 || bus.level !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_full: full=%b afull=%b level=%0d expected 1 1 4", bus.full, bus.afull, bus.level);
    end
    cycle(1, 0, 0, 8'h14);
    n_checks++;
    if (bus.level !== 3'd4 || bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_overflow: level=%0d ovf=%b expected level=4 ovf=1", bus.level, bus.ovf);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.empty !== 1'b0 || bus.dout !== 8'(8'h10 + i)) begin
        n_fail++;
        $display("FAIL drain_data_%0d: empty=%b dout=%h expected empty=0 dout=%h", i, bus.empty, bus.dout, 8'(8'h10 + i));
      end
      cycle(0, 1, 0, 8'h00);
    end
    n_checks++;
    if (dut_status() !== exp_status() || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end: got %b expected %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_full_rw();
    cycle(0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'(8'h30 + i));
    cycle(1, 1, 0, 8'h55);
    n_checks++;
    if (bus.level !== 3'd3 || bus.ovf !== 1'b1 || bus.dout !== 8'h31 || bus.empty !== 1'b0) begin
      n_fail++;
      $display("FAIL full_rw: level=%0d ovf=%b dout=%h empty=%b expected 3 1 31 0", bus.level, bus.ovf, bus.dout, bus.empty);
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (bus.dout !== 8'(8'h30 + i)) begin
        n_fail++;
        $display("FAIL full_rw_drain_%0d: dout=%h expected %h", i, bus.dout, 8'(8'h30 + i));
      end
      cycle(0, 1, 0, 8'h00);
    end
    n_checks++;
    if (dut_status() !== exp_status() || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rw_end: got %b expected %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_stream();
    cycle(0, 0, 1, 8'h00);
    cycle(1, 0, 0, 8'h40);
    cycle(1, 0, 0, 8'h41);
    cycle(0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.dout !== 8'(8'h40 + i) || bus.empty !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_data_%0d: dout=%h empty=%b expected %h 0", i, bus.dout, bus.empty, 8'(8'h40 + i));
      end
      cycle(1, 1, 0, 8'(8'h42 + i));
      n_checks++;
      if (bus.level !== 3'd2 || bus.ovf !== 1'b0 || bus.unf !== 1'b0 || dut_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL stream_status_%0d: got %b expected %b", i, dut_status(), exp_status());
      end
    end
  endtask

  task automatic test_unf_clr();
    cycle(0, 0, 1, 8'h00);
    cycle(0, 1, 0, 8'h00);
    n_checks++;
    if (bus.unf !== 1'b1 || bus.level !== 3'd0) begin
      n_fail++;
      $display("FAIL unf_empty: unf=%b level=%0d expected 1 0", bus.unf, bus.level);
    end
    cycle(0, 0, 1, 8'h00);
    cycle(1, 0, 0, 8'h77);
    cycle(0, 1, 0, 8'h00);
    n_checks++;
    if (bus.unf !== 1'b1 || bus.level !== 3'd1 || dut_status() !== exp_status()) begin
      n_fail++;
      $display("FAIL unf_latency: got %b expected %b", dut_status(), exp_status());
    end
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'(8'h78 + i));
    cycle(0, 0, 1, 8'h00);
    n_checks++;
    if (dut_status() !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL clr_status: got %b expected %b", dut_status(), 8'b1000_0000);
    end
  endtask

  task automatic test_random();
    bit w, r, c;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 2);
      cycle(w, r, c, 8'($urandom));
      n_checks++;
      if (dut_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL random_status_%0d: got %b expected %b", i, dut_status(), exp_status());
      end
      if (!exp_empty()) begin
        n_checks++;
        if (bus.dout !== q[0].data) begin
          n_fail++;
          $display("FAIL random_dout_%0d: got %h expected %h", i, bus.dout, q[0].data);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'(8'h61 + i));
    cycle(0, 0, 0, 8'h00);
    n_checks++;
    if (bus.level !== 3'd3) begin
      n_fail++;
      $display("FAIL async_setup: level=%0d expected 3", bus.level);
    end
    bus.wr = 1'b1; bus.rd = 1'b1; bus.din = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_status() !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b", dut_status(), 8'b1000_0000);
    end
    model_reset();
    bus.wr = 1'b0; bus.rd = 1'b0;
    #2 rst_n = 1'b1;
    cycle(0, 0, 0, 8'h00);
    n_checks++;
    if (dut_status() !== exp_status()) begin
      n_fail++;
      $display("FAIL async_release: got %b expected %b", dut_status(), exp_status());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_ovf();
    test_full_rw();
    test_stream();
    test_unf_clr();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
